cb_config_loader: RTL
=====================

# cb_config_loader

Serial configuration loader that writes the 35-bit SRAM configuration word of one connection box. It hunts a serial stream for a sync header, then shifts in the payload MSB-first into a shadow register. An optional parity check follows. On success it commits the payload atomically onto the box's `sram_in` bus, so the connection box never registers a partially loaded word.

## Interface
- `CFG_WIDTH`, default 35: payload bits, equal to the connection box SRAM width.
- `SYNC_WORD`, default 8'hA5: 8-bit header that precedes every frame.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: `cfg_bit` carries a valid stream bit this cycle.
- `cfg_bit` in 1: serial configuration data.
- `cfg_ready` out 1: loader accepts a bit this cycle. A bit transfers only when `cfg_valid && cfg_ready`.
- `sram_out` out CFG_WIDTH: committed configuration word, driven to the connection box `sram_in`.
- `cfg_done` out 1: one-cycle pulse marking that `sram_out` has just been updated.
- `cfg_error` out 1: one-cycle pulse marking that a frame was rejected (parity build only).
- `cfg_loaded` out 1: sticky flag. It sets on the first successful commit and clears only on `reset`.

## Operation
- **States:** HUNT, SHIFT, PARITY, COMMIT. PARITY exists only with the macro enabled.
- **HUNT**
  - Each accepted bit shifts into an 8-bit header register: `hdr <= {hdr[6:0], cfg_bit}`.
  - When the value after the shift equals `SYNC_WORD`, go to SHIFT. At the same time, clear the payload counter and the header register.
  - Header matching is sliding: it can match at any bit offset.
- **SHIFT**
  - Each accepted bit does `shadow <= {shadow[CFG_WIDTH-2:0], cfg_bit}` and increments the counter.
  - The first payload bit ends up in `sram_out[CFG_WIDTH-1]`.
  - On the CFG_WIDTH-th accepted bit, go to PARITY if the macro is defined, otherwise to COMMIT.
- **PARITY**
  - Accept one bit, then go to COMMIT.
  - The frame passes when XOR(shadow, parity bit) = 0, i.e. even parity over CFG_WIDTH+1 bits.
- **COMMIT** (one cycle, `cfg_ready` = 0)
  - Pass: `sram_out <= shadow`, `cfg_done` = 1, `cfg_loaded` = 1.
  - Fail: `sram_out` is left unchanged and `cfg_error` = 1.
  - Either way the next state is HUNT.
- **Stalls:** `cfg_valid` low in any state holds all state; there is no timeout.
- **Counter:** `$clog2(CFG_WIDTH+1)` bits. It never wraps, because SHIFT exits at CFG_WIDTH.
- **Reset** (in any state, including mid-frame)
  - State goes to HUNT; `hdr`, `shadow` and the counter are cleared.
  - `sram_out` = 0, which drives all connection box switches off and leaves all box outputs high-Z.
  - `cfg_done` = 0, `cfg_error` = 0, `cfg_loaded` = 0.
  - A partial frame is discarded.

## Timing
- `cfg_ready` is combinational: it equals `state != COMMIT`. It is 1 in the first cycle after reset.
- The final frame bit (parity bit, or last payload bit without the macro) is accepted at edge N.
  - COMMIT occupies cycle N→N+1.
  - `sram_out`, `cfg_done` and `cfg_error` change at edge N+1.
  - The pulses last exactly one cycle. `cfg_ready` returns to 1 after edge N+1.
- `sram_out`, `cfg_done`, `cfg_error` and `cfg_loaded` are registered outputs.
- Minimum frame: 8 + CFG_WIDTH + 1 accepted bits plus 1 commit cycle, i.e. 45 cycles at default settings with parity.
- Back-to-back frames are allowed: the header of the next frame may start in the cycle after COMMIT.
- A bit offered during COMMIT is not accepted. The source must hold it until `cfg_ready` is 1.

## Configuration
- `CB_CFG_PARITY_EN` defined:
  - The PARITY state and check are present.
  - A failed frame pulses `cfg_error` and leaves `sram_out` unchanged.
- `CB_CFG_PARITY_EN` undefined:
  - No parity bit is expected; SHIFT goes directly to COMMIT.
  - `cfg_error` is tied to 0.
  - Every complete frame commits.

## Test plan
- **Good frame.** Reset, then stream header 8'hA5, payload 35'h002000001, parity bit 0, with `cfg_valid` held high → `sram_out` = 35'h002000001 at cycle 45 after reset release, with `cfg_done` = 1 for one cycle and `cfg_loaded` = 1.
- **Parity error.** Send the same frame with parity bit 1, after a good frame that loaded 35'h7FFFFFFFF → `cfg_error` pulses once, `sram_out` stays 35'h7FFFFFFFF, and `cfg_done` stays 0.
- **Sliding header match.** Send bits 0,0,1,1,0,1,0,0,1,0,1 (the last 8 bits are 8'hA5), then the payload → the frame is detected at the header's last bit and the payload commits correctly.
- **Stall handling.**
  - Toggle `cfg_valid` randomly, about 50% duty, through a full frame → same commit result as the no-stall case.
  - Assert `cfg_valid` during COMMIT → `cfg_ready` = 0 and no bit is consumed.
- **Reset mid-frame.** Assert `reset` for one cycle after 20 payload bits → all outputs are 0. A fresh frame with payload 35'h000000003 then commits cleanly, with `cfg_error` staying 0.
- **Macro off.** Build without `CB_CFG_PARITY_EN` and send header + 35'h000000007 with no parity bit → the commit happens one cycle after the last payload bit and `cfg_error` is never asserted.

Source files
------------

// File: rtl/cb_config_loader.sv
// cb_config_loader
//   Serial configuration loader for one connection box. Hunts the serial
//   stream for an 8-bit sync header, then shifts a CFG_WIDTH-bit payload
//   into a shadow register, MSB first. When the frame is complete, the
//   payload is copied onto sram_out in a single cycle, so the box never
//   sees a partially loaded word.
//
//   Optional feature macro: CB_CFG_PARITY_EN
//     defined   : one even-parity bit follows the payload. A failed frame
//                 pulses cfg_error and leaves sram_out untouched.
//     undefined : no parity bit. Every complete frame commits, and
//                 cfg_error is tied low.
//
// Ports
//   clk        in  : single clock, rising edge
//   reset      in  : synchronous, active-high reset
//   cfg_valid  in  : cfg_bit is valid this cycle
//   cfg_bit    in  : serial configuration data
//   cfg_ready  out : loader accepts a bit this cycle (low only in COMMIT)
//   sram_out   out : committed configuration word, drives the box sram_in
//   cfg_done   out : one-cycle pulse, sram_out was just updated
//   cfg_error  out : one-cycle pulse, a frame was rejected by parity
//   cfg_loaded out : sticky, set by the first successful commit
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HUNT     | sliding search for SYNC_WORD in the accepted bit stream
// SHIFT    | collecting CFG_WIDTH payload bits into the shadow register
// PARITY   | waiting for the parity bit (parity build only)
// COMMIT   | one cycle; copy shadow to sram_out or flag the error

module cb_config_loader #(
  parameter int          CFG_WIDTH = 35,
  parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_ready,
  output logic [CFG_WIDTH-1:0] sram_out,
  output logic                 cfg_done,
  output logic                 cfg_error,
  output logic                 cfg_loaded
);

  localparam int CNT_W = $clog2(CFG_WIDTH + 1);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef CB_CFG_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif
  localparam logic [1:0] ST_COMMIT = 2'd3;

  logic [1:0]           state;
  logic [7:0]           hdr;
  logic [7:0]           hdr_next;
  logic [CFG_WIDTH-1:0] shadow;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 accept;
  logic                 last_payload;

  assign cfg_ready    = (state != ST_COMMIT);
  assign accept       = cfg_valid && cfg_ready;
  assign hdr_next     = {hdr[6:0], cfg_bit};
  assign last_payload = (bit_cnt == CNT_W'(CFG_WIDTH - 1));

`ifdef CB_CFG_PARITY_EN
  // Result of the parity check, consumed in COMMIT.
  logic frame_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_HUNT;
      hdr        <= '0;
      shadow     <= '0;
      bit_cnt    <= '0;
      frame_ok   <= 1'b0;
      sram_out   <= '0;
      cfg_done   <= 1'b0;
      cfg_error  <= 1'b0;
      cfg_loaded <= 1'b0;
    end else begin
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (accept) begin
            // Clearing hdr on a match means the next hunt starts from a
            // clean history.
            if (hdr_next == SYNC_WORD) begin
              state   <= ST_SHIFT;
              hdr     <= '0;
              bit_cnt <= '0;
            end else begin
              hdr <= hdr_next;
            end
          end
        end
        ST_SHIFT: begin
          if (accept) begin
            shadow  <= {shadow[CFG_WIDTH-2:0], cfg_bit};
            bit_cnt <= bit_cnt + 1'b1;
            if (last_payload) begin
              state <= ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (accept) begin
            // Even parity across payload plus parity bit.
            frame_ok <= ~(^shadow ^ cfg_bit);
            state    <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (frame_ok) begin
            sram_out   <= shadow;
            cfg_done   <= 1'b1;
            cfg_loaded <= 1'b1;
          end else begin
            cfg_error <= 1'b1;
          end
          state <= ST_HUNT;
        end
        default: begin
          state <= ST_HUNT;
        end
      endcase
    end
  end
`else
  assign cfg_error = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_HUNT;
      hdr        <= '0;
      shadow     <= '0;
      bit_cnt    <= '0;
      sram_out   <= '0;
      cfg_done   <= 1'b0;
      cfg_loaded <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (accept) begin
            if (hdr_next == SYNC_WORD) begin
              state   <= ST_SHIFT;
              hdr     <= '0;
              bit_cnt <= '0;
            end else begin
              hdr <= hdr_next;
            end
          end
        end
        ST_SHIFT: begin
          if (accept) begin
            shadow  <= {shadow[CFG_WIDTH-2:0], cfg_bit};
            bit_cnt <= bit_cnt + 1'b1;
            if (last_payload) begin
              state <= ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          sram_out   <= shadow;
          cfg_done   <= 1'b1;
          cfg_loaded <= 1'b1;
          state      <= ST_HUNT;
        end
        default: begin
          state <= ST_HUNT;
        end
      endcase
    end
  end
`endif

endmodule
